booth_r4_multiplier: RTL and testbench

Parametrised sequential radix-4 (modified) Booth multiplier with a Start/Ready handshake and run-time signed/unsigned mode. It retires two multiplier bits per clock, so an L_word-bit multiply takes L_word/2+1 cycles instead of one to two cycles per bit. It is the next-generation drop-in for the radix-2 Booth STG multiplier used by the datapath and testbench library, which was fixed at 4 bits and signed only.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_r4_recoder.sv | 12 +
 rtl/booth_r4_multiplier.sv | 99 +++++++++
 tb/tb_booth_r4_multiplier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: controller state encoding,
// the recoded digit format, and the 3-bit window recoding rule.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A radix-4 digit in {-2,-1,0,+1,+2}: magnitude 2 when two=1, sign from neg.
    typedef struct packed {
        logic neg;
        logic two;
        logic nonzero;
    } booth_digit_t;

    function automatic booth_digit_t booth_recode(input logic [2:0] window);
        booth_digit_t digit;
        digit = '0;
        case (window)
            3'b001, 3'b010: digit = '{neg: 1'b0, two: 1'b0, nonzero: 1'b1};
            3'b011:         digit = '{neg: 1'b0, two: 1'b1, nonzero: 1'b1};
            3'b100:         digit = '{neg: 1'b1, two: 1'b1, nonzero: 1'b1};
            3'b101, 3'b110: digit = '{neg: 1'b1, two: 1'b0, nonzero: 1'b1};
            default:        digit = '0;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: maps a 3-bit multiplier window
// (two new bits plus the previous top bit) to a signed digit.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    assign digit = booth_recode(window);

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier with Start/Ready handshake and run-time
// signed/unsigned operand mode; retires two multiplier bits per clock.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int L_word   = 8,
    parameter int N_digits = L_word / 2 + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [L_word-1:0]     word1,
    input  logic [L_word-1:0]     word2,
    input  logic                  signed_mode,
    input  logic                  Start,
    output logic [2*L_word-1:0]   product,
    output logic                  Ready,
    output logic                  Busy
);

    localparam int PW    = 2 * L_word;
    localparam int MW    = L_word + 3;
    localparam int CNT_W = $clog2(N_digits);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [PW-1:0]      mcand_reg;
    logic [MW-1:0]      mplr_reg;
    logic [PW-1:0]      product_reg;

    logic               accept;
    logic               last_digit;
    logic               mcand_ext;
    logic               mplr_ext;
    booth_digit_t       digit;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      operand;
    logic [PW-1:0]      sum;

    // A new Start is taken whenever the datapath is not mid-operation.
    assign accept     = Start && (state_reg != ST_RUN);
    assign last_digit = (cnt_reg == CNT_W'(N_digits - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (Start) state_next = ST_RUN;
            ST_RUN:  if (last_digit) state_next = ST_DONE;
            ST_DONE: if (Start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    assign Ready = (state_reg == ST_DONE);
    assign Busy  = (state_reg == ST_RUN);

    booth_r4_recoder u_recoder (
        .window (mplr_reg[2:0]),
        .digit  (digit)
    );

    // Single adder/subtractor: subtraction is the inverted addend plus a carry-in.
    assign addend  = !digit.nonzero ? '0 :
                     digit.two      ? {mcand_reg[PW-2:0], 1'b0} : mcand_reg;
    assign operand = digit.neg ? ~addend : addend;
    assign sum     = product_reg + operand + PW'(digit.neg);

    assign mcand_ext = signed_mode & word1[L_word-1];
    assign mplr_ext  = signed_mode & word2[L_word-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplr_reg    <= '0;
            product_reg <= '0;
        end else if (accept) begin
            cnt_reg     <= '0;
            mcand_reg   <= {{L_word{mcand_ext}}, word1};
            mplr_reg    <= {mplr_ext, mplr_ext, word2, 1'b0};
            product_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            cnt_reg     <= cnt_reg + 1'b1;
            mcand_reg   <= {mcand_reg[PW-3:0], 2'b00};
            mplr_reg    <= {mplr_reg[MW-1], mplr_reg[MW-1], mplr_reg[MW-1:2]};
            product_reg <= sum;
        end
    end

    assign product = product_reg;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier at L_word = 4, 8 and 16,
// comparing against a plain integer-multiply reference.
module tb_booth_r4_multiplier;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;

    logic [3:0]  w1_4, w2_4;
    logic        s_4, st_4, rdy_4, bsy_4;
    logic [7:0]  p_4;

    logic [7:0]  w1_8, w2_8;
    logic        s_8, st_8, rdy_8, bsy_8;
    logic [15:0] p_8;

    logic [15:0] w1_16, w2_16;
    logic        s_16, st_16, rdy_16, bsy_16;
    logic [31:0] p_16;

    int checks = 0;
    int errors = 0;

    booth_r4_multiplier #(.L_word(4)) dut4 (
        .clock(clock), .reset(reset), .word1(w1_4), .word2(w2_4),
        .signed_mode(s_4), .Start(st_4), .product(p_4), .Ready(rdy_4), .Busy(bsy_4)
    );

    booth_r4_multiplier #(.L_word(8)) dut8 (
        .clock(clock), .reset(reset), .word1(w1_8), .word2(w2_8),
        .signed_mode(s_8), .Start(st_8), .product(p_8), .Ready(rdy_8), .Busy(bsy_8)
    );

    booth_r4_multiplier #(.L_word(16)) dut16 (
        .clock(clock), .reset(reset), .word1(w1_16), .word2(w2_16),
        .signed_mode(s_16), .Start(st_16), .product(p_16), .Ready(rdy_16), .Busy(bsy_16)
    );

    // Reference: interpret operands per mode, multiply as integers, keep 2w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input bit s);
        longint x, y, r, mask;
        mask = (longint'(1) << w) - 1;
        x = longint'(a) & mask;
        y = longint'(b) & mask;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && y[w-1]) y = y - (longint'(1) << w);
        r = x * y;
        mask = (longint'(1) << (2 * w)) - 1;
        return 32'(r & mask);
    endfunction

    task automatic set_inputs(input int w, input logic [15:0] a, input logic [15:0] b,
                              input bit s, input bit st);
        case (w)
            4:       begin w1_4  = a[3:0]; w2_4  = b[3:0]; s_4  = s; st_4  = st; end
            8:       begin w1_8  = a[7:0]; w2_8  = b[7:0]; s_8  = s; st_8  = st; end
            default: begin w1_16 = a;      w2_16 = b;      s_16 = s; st_16 = st; end
        endcase
    endtask

    function automatic bit get_ready(input int w);
        return (w == 4) ? rdy_4 : (w == 8) ? rdy_8 : rdy_16;
    endfunction

    function automatic logic [31:0] get_product(input int w);
        return (w == 4) ? 32'(p_4) : (w == 8) ? 32'(p_8) : p_16;
    endfunction

    // One full operation; operands are scrambled right after the accepting edge.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input bit s, output logic [31:0] p, output int lat);
        @(negedge clock);
        set_inputs(w, a, b, s, 1'b1);
        @(posedge clock); #1;
        set_inputs(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        lat = 1;
        while (!get_ready(w) && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        p = get_product(w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (p_8 !== 16'h0) begin errors++; $display("FAIL reset_product: got %h expected 0000", p_8); end
        checks++;
        if (rdy_8 !== 1'b0 || bsy_8 !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ready=%b busy=%b expected 0/0", rdy_8, bsy_8);
        end
        checks++;
        if (p_16 !== 32'h0 || rdy_4 !== 1'b0) begin
            errors++; $display("FAIL reset_others: got p16=%h rdy4=%b expected 0/0", p_16, rdy_4);
        end
        reset = 1'b0;
        $display("reset: product=%h ready=%b busy=%b", p_8, rdy_8, bsy_8);
    endtask

    task automatic test_directed();
        logic [15:0] a[4] = '{16'h80, 16'hFF, 16'hFF, 16'h03};
        logic [15:0] b[4] = '{16'h80, 16'hFF, 16'hFF, 16'h05};
        bit          s[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_p[4] = '{32'h4000, 32'hFE01, 32'h0001, 32'h000F};
        logic [31:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(8, a[i], b[i], s[i], p, lat);
            $display("directed: %h x %h signed=%0d -> %h latency=%0d", a[i][7:0], b[i][7:0], s[i], p, lat);
            checks++;
            if (p !== exp_p[i]) begin
                errors++; $display("FAIL directed_product[%0d]: got %h expected %h", i, p, exp_p[i]);
            end
            checks++;
            if (lat != 6) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d expected 6", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        int lat;
        run_op(8, 16'h7F, 16'hFF, 1'b1, p, lat);
        checks++;
        if (p !== 32'hFF81) begin errors++; $display("FAIL b2b_first: got %h expected ff81", p); end
        // Start raised in the same cycle Ready is seen; the next edge must accept it.
        set_inputs(8, 16'h03, 16'h05, 1'b1, 1'b1);
        @(posedge clock); #1;
        set_inputs(8, 16'hAA, 16'h55, 1'b0, 1'b0);
        checks++;
        if (bsy_8 !== 1'b1 || rdy_8 !== 1'b0) begin
            errors++; $display("FAIL b2b_no_idle: got busy=%b ready=%b expected 1/0", bsy_8, rdy_8);
        end
        lat = 1;
        while (!rdy_8 && lat < 40) begin @(posedge clock); #1; lat++; end
        $display("back_to_back: 7f x ff -> %h then 03 x 05 -> %h latency=%0d", 16'hFF81, p_8, lat);
        checks++;
        if (p_8 !== 16'h000F || lat != 6) begin
            errors++; $display("FAIL b2b_second: got %h lat %0d expected 000f lat 6", p_8, lat);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] a, b;
        logic [31:0] exp_p;
        int cyc;
        bit busy_ok;
        a = 16'($urandom_range(1, 255));
        b = 16'($urandom_range(1, 255));
        exp_p = ref_mul(8, a, b, 1'b1);
        @(negedge clock);
        set_inputs(8, a, b, 1'b1, 1'b1);
        @(posedge clock); #1;
        set_inputs(8, a, b, 1'b1, 1'b0);
        repeat (2) begin @(posedge clock); #1; end
        set_inputs(8, ~a, a ^ b, 1'b0, 1'b1);
        busy_ok = 1'b1;
        cyc = 3;
        while (!rdy_8 && cyc < 40) begin
            if (bsy_8 !== 1'b1) busy_ok = 1'b0;
            @(posedge clock); #1;
            set_inputs(8, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            cyc++;
        end
        $display("start_ignored: %h x %h -> %h expected %h", a[7:0], b[7:0], p_8, exp_p[15:0]);
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL ignored_busy: got busy dropout expected continuous busy"); end
        checks++;
        if (p_8 !== exp_p[15:0] || cyc != 6) begin
            errors++; $display("FAIL ignored_result: got %h lat %0d expected %h lat 6", p_8, cyc, exp_p[15:0]);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] p;
        int lat;
        @(negedge clock);
        set_inputs(8, 16'hD3, 16'h6B, 1'b1, 1'b1);
        @(posedge clock); #1;
        set_inputs(8, 16'hD3, 16'h6B, 1'b1, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        checks++;
        if (p_8 !== 16'h0 || rdy_8 !== 1'b0 || bsy_8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got p=%h ready=%b busy=%b expected 0000/0/0", p_8, rdy_8, bsy_8);
        end
        #2;
        reset = 1'b0;
        run_op(8, 16'd6, 16'd7, 1'b0, p, lat);
        $display("async_reset: after reset 6 x 7 -> %h", p);
        checks++;
        if (p !== 32'h002A || lat != 6) begin
            errors++; $display("FAIL post_reset_op: got %h lat %0d expected 002a lat 6", p, lat);
        end
    endtask

    task automatic test_exhaustive4();
        logic [31:0] p, exp_p;
        int lat;
        int bad = 0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(4, 16'(a), 16'(b), 1'(s), p, lat);
                    exp_p = ref_mul(4, 16'(a), 16'(b), 1'(s));
                    checks++;
                    if (p !== exp_p || lat != 4) begin
                        errors++; bad++;
                        if (bad < 10)
                            $display("FAIL exh4 %h x %h s=%0d: got %h lat %0d expected %h lat 4",
                                     a[3:0], b[3:0], s, p[7:0], lat, exp_p[7:0]);
                    end
                end
            end
        end
        $display("exhaustive4: 512 operations checked");
    endtask

    task automatic test_random(input int w, input int n);
        logic [31:0] p, exp_p;
        logic [15:0] a, b;
        int lat;
        int bad = 0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < n; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (i == 0) begin a = '1; b = '1; end
                if (i == 1) begin a = 16'h8000 >> (16 - w); b = a; end
                run_op(w, a, b, 1'(s), p, lat);
                exp_p = ref_mul(w, a, b, 1'(s));
                checks++;
                if (p !== exp_p || lat != w / 2 + 2) begin
                    errors++; bad++;
                    if (bad < 10)
                        $display("FAIL rand%0d %h x %h s=%0d: got %h lat %0d expected %h lat %0d",
                                 w, a, b, s, p, lat, exp_p, w / 2 + 2);
                end
            end
        end
        $display("random%0d: %0d operations per mode checked", w, n);
    endtask

    initial begin
        set_inputs(4, '0, '0, 1'b0, 1'b0);
        set_inputs(8, '0, '0, 1'b0, 1'b0);
        set_inputs(16, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_async_reset();
        test_exhaustive4();
        test_random(8, 500);
        test_random(16, 1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
